// File: rtl/dma_pkg.sv
// Shared types, register offsets and bit positions for the Venus DMA CSR block.
package dma_pkg;

  // Byte offsets inside the 64-byte CSR window
  localparam logic [5:0] VENUSDMA_CFG_OFFSET     = 6'h00;
  localparam logic [5:0] VENUSDMA_SRC_OFFSET     = 6'h08;
  localparam logic [5:0] VENUSDMA_DST_OFFSET     = 6'h10;
  localparam logic [5:0] VENUSDMA_LEN_OFFSET     = 6'h18;
  localparam logic [5:0] VENUSDMA_STAT_OFFSET    = 6'h20;
  localparam logic [5:0] VENUSDMA_ERRADDR_OFFSET = 6'h28;
  localparam logic [5:0] VENUSDMA_ERRSRC_OFFSET  = 6'h30;

  // CFG bit positions
  localparam int CFG_GO_BIT     = 0;
  localparam int CFG_IRQ_EN_BIT = 1;
  localparam int CFG_CLR_BIT    = 2;

  // STAT bit positions
  localparam int STAT_ACTIVE_BIT = 0;
  localparam int STAT_DONE_BIT   = 1;
  localparam int STAT_ERROR_BIT  = 2;

  localparam int CSR_IMG_W = 512;

  typedef enum logic [1:0] {
    DMA_AXI_RD_ERR = 2'd0,
    DMA_AXI_WR_ERR = 2'd1,
    DMA_DESC_ERR   = 2'd2,
    DMA_OTHER_ERR  = 2'd3
  } err_src_t;

  typedef enum logic [1:0] {
    DMA_ST_IDLE = 2'd0,
    DMA_ST_RUN  = 2'd1,
    DMA_ST_DONE = 2'd2
  } dma_st_t;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] num_bytes;
  } s_dma_desc_t;

  typedef struct packed {
    logic active;
    logic done;
    logic error;
  } s_dma_status_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    err_src_t    src;
  } s_dma_error_t;

  typedef struct packed {
    logic        csr_wr_en;
    logic [31:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_rd_en;
  } csr_req_t;

  typedef struct packed {
    logic [CSR_IMG_W-1:0] csr_rdata;
  } csr_resp_t;

  // Lay out every register at bits [8k+31:8k] for byte offset k; rest reads 0.
  function automatic logic [CSR_IMG_W-1:0] pack_image(
    input logic        irq_en,
    input logic [31:0] src,
    input logic [31:0] dst,
    input logic [31:0] len,
    input logic [2:0]  stat,
    input logic [31:0] erraddr,
    input err_src_t    errsrc
  );
    logic [CSR_IMG_W-1:0] img;
    logic [31:0]          cfg;
    img = '0;
    cfg = '0;
    cfg[CFG_IRQ_EN_BIT] = irq_en;
    img[8*int'(VENUSDMA_CFG_OFFSET)     +: 32] = cfg;
    img[8*int'(VENUSDMA_SRC_OFFSET)     +: 32] = src;
    img[8*int'(VENUSDMA_DST_OFFSET)     +: 32] = dst;
    img[8*int'(VENUSDMA_LEN_OFFSET)     +: 32] = len;
    img[8*int'(VENUSDMA_STAT_OFFSET)    +: 32] = {29'b0, stat};
    img[8*int'(VENUSDMA_ERRADDR_OFFSET) +: 32] = erraddr;
    img[8*int'(VENUSDMA_ERRSRC_OFFSET)  +: 32] = {30'b0, errsrc};
    return img;
  endfunction

endpackage

// File: rtl/venus_dma_csr.sv
// DMA CSR responder: descriptor/config registers, run-state FSM, start pulse,
// first-error capture, interrupt, and a registered image of the whole window.
module venus_dma_csr
  import dma_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1ffe_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  csr_req_t      csr_req_i,
  output csr_resp_t     csr_resp_o,
  output s_dma_desc_t   dma_desc_o,
  output logic          dma_go_o,
  input  s_dma_status_t dma_status_i,
  input  s_dma_error_t  dma_error_i,
  output logic          dma_irq_o
);

  dma_st_t              state_q, state_d;
  logic                 irq_en_q, irq_en_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [31:0]          len_q, len_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [31:0]          erraddr_q, erraddr_d;
  err_src_t             errsrc_q, errsrc_d;
  logic                 go_q, go_d;
  logic                 irq_q, irq_d;
  logic [CSR_IMG_W-1:0] rdata_q, rdata_d;

  logic       wr_hit;
  logic [5:0] woff;
  logic       wr_cfg, wr_src, wr_dst, wr_len, wr_errsrc;
  logic       go_req, clr_req, locked;

  // The FSM's own active flag duplicates our RUN state, so it is not consumed.
  logic status_active_unused;
  assign status_active_unused = dma_status_i.active;

  // Write decode: only the aligned 64-byte window hits.
  always_comb begin
    wr_hit    = csr_req_i.csr_wr_en && (csr_req_i.csr_waddr[31:6] == BASE_ADDR[31:6]);
    woff      = csr_req_i.csr_waddr[5:0];
    wr_cfg    = wr_hit && (woff == VENUSDMA_CFG_OFFSET);
    wr_src    = wr_hit && (woff == VENUSDMA_SRC_OFFSET);
    wr_dst    = wr_hit && (woff == VENUSDMA_DST_OFFSET);
    wr_len    = wr_hit && (woff == VENUSDMA_LEN_OFFSET);
    wr_errsrc = wr_hit && (woff == VENUSDMA_ERRSRC_OFFSET);
    go_req    = wr_cfg && csr_req_i.csr_wdata[CFG_GO_BIT];
    clr_req   = wr_cfg && csr_req_i.csr_wdata[CFG_CLR_BIT];
    locked    = (state_q == DMA_ST_RUN);
  end

  // Next-state for registers, control FSM, error capture, irq and read image.
  always_comb begin
    state_d   = state_q;
    irq_en_d  = irq_en_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    done_d    = done_q;
    err_d     = err_q;
    erraddr_d = erraddr_q;
    errsrc_d  = errsrc_q;
    go_d      = 1'b0;

    if (wr_cfg)            irq_en_d = csr_req_i.csr_wdata[CFG_IRQ_EN_BIT];
    if (wr_src && !locked) src_d    = csr_req_i.csr_wdata;
    if (wr_dst && !locked) dst_d    = csr_req_i.csr_wdata;
    if (wr_len && !locked) len_d    = csr_req_i.csr_wdata;

    // ERRSRC write clears the error record; anything that sets error below wins.
    if (wr_errsrc) begin
      err_d     = 1'b0;
      erraddr_d = '0;
      errsrc_d  = DMA_AXI_RD_ERR;
    end

    case (state_q)
      DMA_ST_RUN: begin
        if (dma_status_i.done || dma_status_i.error) state_d = DMA_ST_DONE;
        if (dma_status_i.done)  done_d = 1'b1;
        if (dma_status_i.error) err_d  = 1'b1;
      end
      DMA_ST_DONE: begin
        if (go_req) begin
          // Zero-length transfers complete immediately without a start pulse.
          state_d = (len_q == '0) ? DMA_ST_DONE : DMA_ST_RUN;
          done_d  = (len_q == '0);
          go_d    = (len_q != '0);
        end else if (clr_req) begin
          state_d = DMA_ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        if (go_req) begin
          state_d = (len_q == '0) ? DMA_ST_DONE : DMA_ST_RUN;
          done_d  = (len_q == '0);
          go_d    = (len_q != '0);
        end
      end
    endcase

    // First error is kept; later reports are dropped until software clears it.
    if (dma_error_i.valid && !err_q) begin
      err_d     = 1'b1;
      erraddr_d = dma_error_i.addr;
      errsrc_d  = dma_error_i.src;
    end

    irq_d = irq_en_q && (done_q || err_q);

    rdata_d = rdata_q;
    if (csr_req_i.csr_rd_en)
      rdata_d = pack_image(irq_en_q, src_q, dst_q, len_q,
                           {err_q, done_q, (state_q == DMA_ST_RUN)},
                           erraddr_q, errsrc_q);
  end

  // State registers; reset also returns the FSM to IDLE mid-transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DMA_ST_IDLE;
      irq_en_q  <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      erraddr_q <= '0;
      errsrc_q  <= DMA_AXI_RD_ERR;
      go_q      <= 1'b0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      irq_en_q  <= irq_en_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      done_q    <= done_d;
      err_q     <= err_d;
      erraddr_q <= erraddr_d;
      errsrc_q  <= errsrc_d;
      go_q      <= go_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  // Output drive: descriptor is a straight view of the locked registers.
  always_comb begin
    dma_desc_o.src_addr  = src_q;
    dma_desc_o.dst_addr  = dst_q;
    dma_desc_o.num_bytes = len_q;
    dma_go_o             = go_q;
    dma_irq_o            = irq_q;
    csr_resp_o.csr_rdata = rdata_q;
  end

endmodule

// File: tb/tb_venus_dma_csr.sv
// Directed, table-driven bench for venus_dma_csr.
module tb_venus_dma_csr;
  import dma_pkg::*;

  localparam logic [31:0] BASE = 32'h1ffe_0000;

  logic          clk = 1'b0;
  logic          rst;
  csr_req_t      req;
  csr_resp_t     resp;
  s_dma_desc_t   desc;
  logic          go;
  s_dma_status_t status;
  s_dma_error_t  err;
  logic          irq;

  always #5 clk = ~clk;

  venus_dma_csr #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .csr_req_i(req), .csr_resp_o(resp),
    .dma_desc_o(desc), .dma_go_o(go), .dma_status_i(status),
    .dma_error_i(err), .dma_irq_o(irq)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        rd;
    logic        sd;
    logic        se;
    logic        ev;
    logic [31:0] ea;
    logic [1:0]  es;
    logic        xgo;
    logic        xirq;
    logic        chk_rd;
    logic [5:0]  roff;
    logic [31:0] xrd;
    logic        chk_desc;
    logic [31:0] xsrc;
    logic [31:0] xdst;
    logic [31:0] xlen;
  } vec_t;

  vec_t vq[$];
  vec_t v;

  task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  function automatic vec_t nv(input string n, input logic xgo, input logic xirq);
    vec_t r;
    r = '{name: n, wr: 0, wa: 0, wd: 0, rd: 0, sd: 0, se: 0, ev: 0, ea: 0, es: 0,
          xgo: xgo, xirq: xirq, chk_rd: 0, roff: 0, xrd: 0,
          chk_desc: 0, xsrc: 0, xdst: 0, xlen: 0};
    return r;
  endfunction

  function automatic vec_t W(input string n, input logic [31:0] a, input logic [31:0] d,
                             input logic xgo, input logic xirq);
    vec_t r;
    r = nv(n, xgo, xirq);
    r.wr = 1; r.wa = a; r.wd = d;
    return r;
  endfunction

  function automatic vec_t R(input string n, input logic [5:0] off, input logic [31:0] x,
                             input logic xirq);
    vec_t r;
    r = nv(n, 1'b0, xirq);
    r.rd = 1; r.chk_rd = 1; r.roff = off; r.xrd = x;
    return r;
  endfunction

  function automatic vec_t E(input string n, input logic [31:0] a, input logic [1:0] s,
                             input logic xirq);
    vec_t r;
    r = nv(n, 1'b0, xirq);
    r.ev = 1; r.ea = a; r.es = s;
    return r;
  endfunction

  function automatic vec_t S(input string n, input logic d, input logic e, input logic xirq);
    vec_t r;
    r = nv(n, 1'b0, xirq);
    r.sd = d; r.se = e;
    return r;
  endfunction

  task automatic idle_inputs();
    req    = '0;
    status = '0;
    err    = '0;
  endtask

  // Drive one vector for one clock, then check just after the edge.
  task automatic apply(input vec_t t);
    req.csr_wr_en = t.wr;
    req.csr_waddr = t.wa;
    req.csr_wdata = t.wd;
    req.csr_rd_en = t.rd;
    status.active = 1'b0;
    status.done   = t.sd;
    status.error  = t.se;
    err.valid     = t.ev;
    err.addr      = t.ea;
    err.src       = err_src_t'(t.es);
    @(posedge clk);
    #1;
    idle_inputs();
    chk32({t.name, ".go"},  {31'b0, go},  {31'b0, t.xgo});
    chk32({t.name, ".irq"}, {31'b0, irq}, {31'b0, t.xirq});
    if (t.chk_rd)
      chk32({t.name, ".rdata"}, resp.csr_rdata[8*int'(t.roff) +: 32], t.xrd);
    if (t.chk_desc) begin
      chk32({t.name, ".src"}, desc.src_addr,  t.xsrc);
      chk32({t.name, ".dst"}, desc.dst_addr,  t.xdst);
      chk32({t.name, ".len"}, desc.num_bytes, t.xlen);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    // Start a transfer, lock the descriptor, complete, clear
    vq.push_back(W("wr_src",  BASE | 32'h08, 32'h8000_0000, 0, 0));
    vq.push_back(W("wr_dst",  BASE | 32'h10, 32'h8001_0000, 0, 0));
    vq.push_back(W("wr_len",  BASE | 32'h18, 32'h0000_0100, 0, 0));
    vq.push_back(W("go",      BASE | 32'h00, 32'h3, 1, 0));
    v = R("stat_run", 6'h20, 32'h1, 0);
    v.chk_desc = 1; v.xsrc = 32'h8000_0000; v.xdst = 32'h8001_0000; v.xlen = 32'h100;
    vq.push_back(v);
    vq.push_back(W("src_locked_wr", BASE | 32'h08, 32'hdead_beef, 0, 0));
    vq.push_back(R("src_locked", 6'h08, 32'h8000_0000, 0));
    vq.push_back(R("cfg_rd",     6'h00, 32'h2, 0));
    vq.push_back(S("fsm_done", 1, 0, 0));
    vq.push_back(R("stat_done",  6'h20, 32'h2, 1));
    vq.push_back(W("clr",        BASE | 32'h00, 32'h4, 0, 1));
    vq.push_back(R("stat_clr",   6'h20, 32'h0, 0));
    // Zero-length GO goes straight to DONE with no pulse
    vq.push_back(W("len0",       BASE | 32'h18, 32'h0, 0, 0));
    vq.push_back(W("go_len0",    BASE | 32'h00, 32'h1, 0, 0));
    vq.push_back(R("stat_len0",  6'h20, 32'h2, 0));
    // GO from DONE clears done and restarts; FSM error ends the run
    vq.push_back(W("len40",      BASE | 32'h18, 32'h40, 0, 0));
    vq.push_back(W("go_from_done", BASE | 32'h00, 32'h1, 1, 0));
    vq.push_back(R("stat_rerun", 6'h20, 32'h1, 0));
    vq.push_back(S("fsm_err", 0, 1, 0));
    vq.push_back(R("stat_err",   6'h20, 32'h4, 0));
    vq.push_back(W("errsrc_clr0", BASE | 32'h30, 32'h0, 0, 0));
    vq.push_back(R("stat_errclr", 6'h20, 32'h0, 0));
    vq.push_back(W("clr2",       BASE | 32'h00, 32'h4, 0, 0));
    // First-error capture, later error dropped, cleared by ERRSRC write
    vq.push_back(E("err1", 32'h1234, 2'd0, 0));
    vq.push_back(E("err2", 32'h5678, 2'd1, 0));
    vq.push_back(R("erraddr",    6'h28, 32'h1234, 0));
    vq.push_back(R("errsrc",     6'h30, 32'h0, 0));
    vq.push_back(R("stat_cap",   6'h20, 32'h4, 0));
    vq.push_back(W("errsrc_wr",  BASE | 32'h30, 32'hffff_ffff, 0, 0));
    vq.push_back(R("erraddr_clr", 6'h28, 32'h0, 0));
    vq.push_back(R("stat_clr3",  6'h20, 32'h0, 0));
    // Capture beats a same-cycle ERRSRC write
    v = W("cap_vs_clr", BASE | 32'h30, 32'h0, 0, 0);
    v.ev = 1; v.ea = 32'h9abc; v.es = 2'd2;
    vq.push_back(v);
    vq.push_back(R("erraddr_win", 6'h28, 32'h9abc, 0));
    vq.push_back(R("errsrc_win",  6'h30, 32'h2, 0));
    vq.push_back(W("errsrc_clr4", BASE | 32'h30, 32'h0, 0, 0));
    // Interrupt from error with IRQ_EN set
    vq.push_back(W("irq_en",     BASE | 32'h00, 32'h2, 0, 0));
    vq.push_back(E("err_irq", 32'h1, 2'd3, 0));
    vq.push_back(nv("irq_up", 0, 1));
    vq.push_back(W("errsrc_clr5", BASE | 32'h30, 32'h0, 0, 1));
    vq.push_back(nv("irq_down", 0, 0));
    // Decode corners: out-of-window, read-only STAT, read/write same cycle, hold
    vq.push_back(W("miss_wr",    BASE | 32'h48, 32'h5, 0, 0));
    vq.push_back(R("src_nomiss", 6'h08, 32'h8000_0000, 0));
    vq.push_back(W("stat_ro_wr", BASE | 32'h20, 32'hffff, 0, 0));
    vq.push_back(R("stat_ro",    6'h20, 32'h0, 0));
    v = W("rw_same", BASE | 32'h10, 32'h1111, 0, 0);
    v.rd = 1; v.chk_rd = 1; v.roff = 6'h10; v.xrd = 32'h8001_0000;
    vq.push_back(v);
    vq.push_back(R("dst_new",    6'h10, 32'h1111, 0));
    v = nv("rdata_hold", 0, 0);
    v.chk_rd = 1; v.roff = 6'h10; v.xrd = 32'h1111;
    vq.push_back(v);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk32("rst.rdata_any", {31'b0, |resp.csr_rdata}, 32'h0);
    chk32("rst.go",  {31'b0, go},  32'h0);
    chk32("rst.irq", {31'b0, irq}, 32'h0);
    chk32("rst.desc_len", desc.num_bytes, 32'h0);
    apply(R("rst_read", 6'h20, 32'h0, 0));
    chk32("rst.rdata_all", {31'b0, |resp.csr_rdata}, 32'h0);

    foreach (vq[i]) apply(vq[i]);

    // Reset mid-RUN clears everything asynchronously, then GO still works
    apply(W("mr_len", BASE | 32'h18, 32'h8, 0, 0));
    apply(W("mr_go",  BASE | 32'h00, 32'h3, 1, 0));
    #2;
    rst = 1'b1;
    #1;
    chk32("mr.go",       {31'b0, go},  32'h0);
    chk32("mr.irq",      {31'b0, irq}, 32'h0);
    chk32("mr.rdata",    {31'b0, |resp.csr_rdata}, 32'h0);
    chk32("mr.desc_src", desc.src_addr,  32'h0);
    chk32("mr.desc_len", desc.num_bytes, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(W("post_len", BASE | 32'h18, 32'h20, 0, 0));
    apply(W("post_go",  BASE | 32'h00, 32'h1, 1, 0));
    v = R("post_stat", 6'h20, 32'h1, 0);
    v.chk_desc = 1; v.xsrc = 32'h0; v.xdst = 32'h0; v.xlen = 32'h20;
    apply(v);
    apply(R("post_src", 6'h08, 32'h0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
